arbiter_4_rr: RTL

Four-requester round-robin arbiter for a shared resource. It issues one registered one-hot grant at a time. The grant index and a grant-valid flag are exactly the select and enable inputs of the team's 2-to-4 decoder, so the decoder can drive the one-hot grant lines directly. A hold timer preempts a requester that holds the resource too long while others are waiting. The block sits between the requesting units and the shared resource's select decoder.

---
 rtl/arbiter_4_rr.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/arbiter_4_rr.sv
// arbiter_4_rr: four-requester round-robin arbiter with a registered one-hot
// grant, a decoder-compatible index/valid pair and a hold-time preemption
// timer. Every grant change passes through one idle cycle, so the downstream
// 2-to-4 decoder never switches directly from one requester to another.
module arbiter_4_rr #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       enable,
  input  logic [0:3] req,
  output logic [0:3] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Saturation value of the hold timer; the timer is idle when MAX_HOLD is 0.
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LIM = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  // One-hot encoding in decoder numbering: index 0 drives bit [0].
  function automatic logic [0:3] onehot4(input logic [1:0] idx);
    logic [0:3] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting at ptr; returns {found, winner}. The loop
  // runs from lowest to highest priority so the last hit is the winner.
  function automatic logic [2:0] rr_pick(input logic [0:3] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] ptr_r;
  logic [7:0] hold_cnt_r;

  logic [2:0] pick_s;
  logic       owner_req_s;
  logic       others_req_s;
  logic       preempt_cond_s;
  logic       do_grant_s;
  logic       do_release_s;
  logic       do_preempt_s;

  logic [0:3] grant_nxt_s;
  logic [1:0] grant_idx_nxt_s;
  logic       grant_valid_nxt_s;
  logic       preempt_nxt_s;
  logic [1:0] ptr_nxt_s;
  logic [7:0] hold_cnt_nxt_s;

  assign pick_s         = rr_pick(req, ptr_r);
  assign owner_req_s    = req[grant_idx];
  assign others_req_s   = |(req & ~onehot4(grant_idx));
  assign preempt_cond_s = HOLD_EN && owner_req_s && (hold_cnt_r == HOLD_LIM) && others_req_s;

  // State register and all registered outputs, with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      hold_cnt_r  <= 8'd0;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      grant       <= grant_nxt_s;
      grant_idx   <= grant_idx_nxt_s;
      grant_valid <= grant_valid_nxt_s;
      preempt     <= preempt_nxt_s;
    end
  end

  // Next-state decision: arbitrate from IDLE, leave GRANT on release or preemption.
  always_comb begin
    state_nxt_s  = state_r;
    do_grant_s   = 1'b0;
    do_release_s = 1'b0;
    do_preempt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && pick_s[2]) begin
          state_nxt_s = GRANT;
          do_grant_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          state_nxt_s  = IDLE;
          do_release_s = 1'b1;
        end else if (preempt_cond_s) begin
          state_nxt_s  = IDLE;
          do_preempt_s = 1'b1;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and hold timer.
  always_comb begin
    grant_nxt_s       = grant;
    grant_idx_nxt_s   = grant_idx;
    grant_valid_nxt_s = grant_valid;
    preempt_nxt_s     = 1'b0;
    ptr_nxt_s         = ptr_r;
    hold_cnt_nxt_s    = hold_cnt_r;
    if (do_grant_s) begin
      grant_nxt_s       = onehot4(pick_s[1:0]);
      grant_idx_nxt_s   = pick_s[1:0];
      grant_valid_nxt_s = 1'b1;
      ptr_nxt_s         = pick_s[1:0] + 2'd1;
      hold_cnt_nxt_s    = 8'd0;
    end else if (do_release_s || do_preempt_s) begin
      grant_nxt_s       = 4'b0000;
      grant_valid_nxt_s = 1'b0;
      preempt_nxt_s     = do_preempt_s;
      hold_cnt_nxt_s    = 8'd0;
    end else if (state_r == GRANT) begin
      if (HOLD_EN && (hold_cnt_r < HOLD_LIM)) begin
        hold_cnt_nxt_s = hold_cnt_r + 8'd1;
      end else begin
        hold_cnt_nxt_s = hold_cnt_r;
      end
    end else begin
      hold_cnt_nxt_s = hold_cnt_r;
    end
  end

endmodule
